// File: rtl/alu_mc_pkg.sv
// alu_mc shared definitions: opcodes, FSM states, flag bundle.
// Reset flag value has z set, matching the all-zero result register.
package alu_mc_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SHL  = 4'd2;
  localparam logic [3:0] OP_SHR  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_PASS = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_DIV  = 4'd9;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  typedef struct packed {
    logic co;
    logic v;
    logic z;
    logic n;
    logic hc;
    logic dz;
  } flags_t;

  localparam flags_t FLAGS_RST = '{
    co: 1'b0, v: 1'b0, z: 1'b1,
    n: 1'b0, hc: 1'b0, dz: 1'b0
  };

endpackage

// File: rtl/alu_mc_muldiv.sv
// Iterative unsigned shift-add multiplier and restoring divider.
// done/lo/hi present the final step combinationally on the last RUN edge.
module alu_mc_muldiv
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, step;
  logic [WIDTH-1:0]     opnd_q, opnd_d, diff;
  logic                 div_q, div_d;
  logic [WIDTH:0]       madd, rs;

  // acc holds {partial, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    madd = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
         + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rs   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff = rs[WIDTH-1:0] - opnd_q;
    if (!div_q) begin
      step = {madd, acc_q[WIDTH-1:1]};
    end else if (rs >= {1'b0, opnd_q}) begin
      step = {diff, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      step = {rs[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  assign done = en && (state_q == ST_RUN) && (cnt_q == LAST);
  assign lo   = step[WIDTH-1:0];
  assign hi   = step[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    if (en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            acc_d   = {{WIDTH{1'b0}}, is_div ? a : b};
            opnd_d  = is_div ? b : a;
            div_d   = is_div;
          end
        end
        ST_RUN: begin
          acc_d = step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle datapath with per-nibble decimal
// correction, registered results/flags and an iterative mul/div unit.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int BCD_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             bcd,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             out_valid,
  output logic             busy,
  output logic             co,
  output logic             v,
  output logic             z,
  output logic             n,
  output logic             hc,
  output logic             dz
);

  localparam int NN = WIDTH / 4;

  logic             is_sub, is_as, dec, is_mc;
  logic             accept, start, mc_done;
  logic [WIDTH-1:0] bb, dsum, res, hres, mlo, mhi;
  logic [WIDTH:0]   bsum;
  flags_t           fl, mf;

  logic [WIDTH-1:0] out_q, out_d, hi_q, hi_d;
  flags_t           flags_q, flags_d;
  logic             ov_q, ov_d, busy_q, busy_d;
  logic             mdiv_q, mdiv_d;

  assign is_sub   = op == OP_SUB;
  assign is_as    = (op == OP_ADD) || is_sub;
  assign dec      = (BCD_EN != 0) && bcd && is_as;
  assign is_mc    = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
  assign in_ready = !busy_q && en;
  assign accept   = in_valid && in_ready;
  assign start    = accept && is_mc;

  assign bb   = is_sub ? ~b : b;
  assign bsum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};

  // Nibble carries ripple through the previous generate block
  for (genvar i = 0; i < NN; i++) begin : g_nib
    logic       cin, cout, gt9;
    logic [4:0] s;
    logic [3:0] r;
    if (i == 0) begin : g_c0
      assign cin = ci;
    end else begin : g_cn
      assign cin = g_nib[i-1].cout;
    end
    assign s   = 5'(a[4*i+:4]) + 5'(bb[4*i+:4]) + 5'(cin);
    assign gt9 = s > 5'd9;
    always_comb begin
      r    = s[3:0];
      cout = s[4];
      if (dec && is_sub && !s[4]) begin
        r = s[3:0] - 4'd6;
      end
      if (dec && !is_sub && gt9) begin
        r    = s[3:0] + 4'd6;
        cout = 1'b1;
      end
    end
    assign dsum[4*i+:4] = r;
  end

  always_comb begin
    res  = a;
    hres = '0;
    fl   = '0;
    unique case (1'b1)
      is_as: begin
        res   = dec ? dsum : bsum[WIDTH-1:0];
        fl.co = dec ? g_nib[NN-1].cout : bsum[WIDTH];
        fl.hc = g_nib[0].cout;
        fl.v  = (a[WIDTH-1] == bb[WIDTH-1])
             && (bsum[WIDTH-1] != a[WIDTH-1]);
      end
      op == OP_SHL: begin
        res   = {a[WIDTH-2:0], ci};
        fl.co = a[WIDTH-1];
      end
      op == OP_SHR: begin
        res   = {ci, a[WIDTH-1:1]};
        fl.co = a[0];
      end
      op == OP_OR:  res = a | b;
      op == OP_AND: res = a & b;
      op == OP_XOR: res = a ^ b;
      op == OP_DIV: begin
        res   = '1;
        hres  = a;
        fl.dz = 1'b1;
      end
      default: res = a;
    endcase
    fl.n = res[WIDTH-1];
    fl.z = res == '0;
  end

  alu_mc_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .start  (start),
    .is_div (op == OP_DIV),
    .a      (a),
    .b      (b),
    .done   (mc_done),
    .lo     (mlo),
    .hi     (mhi)
  );

  always_comb begin
    mf    = '0;
    mf.co = !mdiv_q && (mhi != '0);
    mf.z  = mdiv_q ? (mlo == '0) : ({mhi, mlo} == '0);
    mf.n  = mlo[WIDTH-1];
  end

  always_comb begin
    out_d   = out_q;
    hi_d    = hi_q;
    flags_d = flags_q;
    ov_d    = ov_q;
    busy_d  = busy_q;
    mdiv_d  = mdiv_q;
    if (en) begin
      ov_d = 1'b0;
      if (accept && !is_mc) begin
        out_d   = res;
        hi_d    = hres;
        flags_d = fl;
        ov_d    = 1'b1;
      end
      if (start) begin
        busy_d = 1'b1;
        mdiv_d = op == OP_DIV;
      end
      if (mc_done) begin
        out_d   = mlo;
        hi_d    = mhi;
        flags_d = mf;
        ov_d    = 1'b1;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      hi_q    <= '0;
      flags_q <= FLAGS_RST;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
      mdiv_q  <= 1'b0;
    end else begin
      out_q   <= out_d;
      hi_q    <= hi_d;
      flags_q <= flags_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
      mdiv_q  <= mdiv_d;
    end
  end

  assign out       = out_q;
  assign hi        = hi_q;
  assign out_valid = ov_q;
  assign busy      = busy_q;
  assign co        = flags_q.co;
  assign v         = flags_q.v;
  assign z         = flags_q.z;
  assign n         = flags_q.n;
  assign hc        = flags_q.hc;
  assign dz        = flags_q.dz;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=8): directed cases plus random ops
// checked against an integer-arithmetic reference model.
module tb_alu_mc;

  logic       clk = 1'b0;
  logic       rst_n, en, in_valid, in_ready;
  logic [3:0] op;
  logic [7:0] a, b, out, hi;
  logic       ci, bcd, out_valid, busy;
  logic       co, v, z, n, hc, dz;

  int nvec = 0;
  int nerr = 0;

  alu_mc dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .ci(ci), .bcd(bcd),
    .out(out), .hi(hi), .out_valid(out_valid), .busy(busy),
    .co(co), .v(v), .z(z), .n(n), .hc(hc), .dz(dz)
  );

  always #5 clk = ~clk;

  // returns {out, hi, co, v, z, n, hc, dz}
  function automatic logic [21:0] model(int op_i, int x, int y, int c_i, int d_i);
    int o, h, fco, fv, fz, fhc, fdz, bb, s, sv, c, nb, p;
    o = 0; h = 0; fco = 0; fv = 0; fhc = 0; fdz = 0;
    case (op_i)
      0, 1: begin
        bb = (op_i == 1) ? 255 - y : y;
        s  = x + bb + c_i;
        sv = (x > 127 ? x - 256 : x) + (bb > 127 ? bb - 256 : bb) + c_i;
        fv = (sv > 127 || sv < -128) ? 1 : 0;
        if (d_i == 0) begin
          o   = s % 256;
          fco = s / 256;
          fhc = ((x % 16) + (bb % 16) + c_i) / 16;
        end else begin
          c = c_i;
          for (int k = 0; k < 2; k++) begin
            nb = ((x >> (4 * k)) % 16) + ((bb >> (4 * k)) % 16) + c;
            if (op_i == 0) begin
              c = (nb > 9) ? 1 : 0;
              if (c == 1) nb = nb + 6;
            end else begin
              c = (nb > 15) ? 1 : 0;
              if (c == 0) nb = nb - 6;
            end
            o = o + (((nb % 16) + 16) % 16) * (k == 0 ? 1 : 16);
            if (k == 0) fhc = c;
          end
          fco = c;
        end
      end
      2: begin o = (x * 2 + c_i) % 256; fco = x / 128; end
      3: begin o = c_i * 128 + x / 2; fco = x % 2; end
      4: o = x | y;
      5: o = x & y;
      6: o = x ^ y;
      8: begin
        p = x * y; o = p % 256; h = p / 256;
        fco = (h != 0) ? 1 : 0;
      end
      9: begin
        if (y == 0) begin o = 255; h = x; fdz = 1; end
        else begin o = x / y; h = x % y; end
      end
      default: o = x;
    endcase
    if (op_i == 8) fz = (p == 0) ? 1 : 0;
    else fz = (o == 0) ? 1 : 0;
    return {8'(o), 8'(h), 1'(fco), 1'(fv), 1'(fz), 1'(o / 128), 1'(fhc), 1'(fdz)};
  endfunction

  // Issue one op, wait (bounded) for out_valid, return what was observed.
  // A foreign op is pulsed on in_valid mid-run; stall_at drops en for 3 edges.
  task automatic drive(input int op_i, x, y, c_i, d_i, stall_at,
                       output logic [7:0] ro, rh, output logic [5:0] rf,
                       output int edges, bad);
    @(negedge clk);
    op = 4'(op_i); a = 8'(x); b = 8'(y);
    ci = 1'(c_i); bcd = 1'(d_i); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0;
    bad = 0;
    while (out_valid !== 1'b1 && edges < 40) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
      in_valid = (edges == 3);
      if (edges == 3) begin op = 4'd0; a = 8'h11; b = 8'h22; end
      en = !(stall_at >= 0 && edges >= stall_at && edges < stall_at + 3);
      @(posedge clk); #1;
      edges++;
    end
    in_valid = 1'b0;
    en = 1'b1;
    ro = out; rh = hi; rf = {co, v, z, n, hc, dz};
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0;
    op = '0; a = '0; b = '0; ci = 1'b0; bcd = 1'b0;
    #12;
    nvec++;
    if ({out, hi, out_valid, busy, co, v, z, n, hc, dz} !== {16'h0, 2'b00, 6'b001000}) begin
      nerr++;
      $display("FAIL reset_values got out=%h hi=%h ov=%b busy=%b fl=%b want 00 00 0 0 001000",
               out, hi, out_valid, busy, {co, v, z, n, hc, dz});
    end
    @(negedge clk); rst_n = 1'b1; #1;
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL reset_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_add;
    logic [7:0] ro, rh; logic [5:0] rf; int ed, bad;
    drive(0, 'h7F, 'h01, 0, 0, -1, ro, rh, rf, ed, bad);
    nvec++;
    if ({ro, rh, rf} !== {8'h80, 8'h00, 6'b010110} || ed != 0) begin
      nerr++;
      $display("FAIL add_ovf got out=%h hi=%h fl=%b lat=%0d want 80 00 010110 0", ro, rh, rf, ed);
    end
  endtask

  task automatic test_bcd;
    logic [7:0] ro, rh; logic [5:0] rf; int ed, bad;
    drive(0, 'h45, 'h38, 0, 1, -1, ro, rh, rf, ed, bad);
    nvec++;
    if ({ro, rh, rf} !== {8'h83, 8'h00, 6'b000110}) begin
      nerr++; $display("FAIL bcd_add got out=%h hi=%h fl=%b want 83 00 000110", ro, rh, rf);
    end
    drive(1, 'h42, 'h15, 1, 1, -1, ro, rh, rf, ed, bad);
    nvec++;
    if ({ro, rh, rf} !== {8'h27, 8'h00, 6'b100000}) begin
      nerr++; $display("FAIL bcd_sub got out=%h hi=%h fl=%b want 27 00 100000", ro, rh, rf);
    end
    drive(0, 'h99, 'h01, 0, 1, -1, ro, rh, rf, ed, bad);
    nvec++;
    if ({ro, rh, rf} !== {8'h00, 8'h00, 6'b101010}) begin
      nerr++; $display("FAIL bcd_wrap got out=%h hi=%h fl=%b want 00 00 101010", ro, rh, rf);
    end
  endtask

  task automatic test_mul;
    logic [7:0] ro, rh; logic [5:0] rf; int ed, bad;
    drive(8, 'hFF, 'hFF, 0, 0, -1, ro, rh, rf, ed, bad);
    nvec++;
    if ({ro, rh, rf} !== {8'h01, 8'hFE, 6'b100000} || ed != 8) begin
      nerr++;
      $display("FAIL mul_ff got out=%h hi=%h fl=%b lat=%0d want 01 FE 100000 8", ro, rh, rf, ed);
    end
    nvec++;
    if (bad != 0) begin
      nerr++; $display("FAIL mul_ready_busy got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_div;
    logic [7:0] ro, rh; logic [5:0] rf; int ed, bad;
    drive(9, 200, 7, 0, 0, -1, ro, rh, rf, ed, bad);
    nvec++;
    if ({ro, rh, rf} !== {8'h1C, 8'h04, 6'b000000} || ed != 8 || bad != 0) begin
      nerr++;
      $display("FAIL div_200_7 got out=%h hi=%h fl=%b lat=%0d bad=%0d want 1C 04 000000 8 0",
               ro, rh, rf, ed, bad);
    end
    drive(9, 200, 0, 0, 0, -1, ro, rh, rf, ed, bad);
    nvec++;
    if ({ro, rh, rf} !== {8'hFF, 8'hC8, 6'b000101} || ed != 0) begin
      nerr++;
      $display("FAIL div_zero got out=%h hi=%h fl=%b lat=%0d want FF C8 000101 0", ro, rh, rf, ed);
    end
  endtask

  task automatic test_shift;
    logic [7:0] ro, rh; logic [5:0] rf; int ed, bad;
    drive(3, 'h81, 0, 1, 0, -1, ro, rh, rf, ed, bad);
    nvec++;
    if ({ro, rh, rf} !== {8'hC0, 8'h00, 6'b100100}) begin
      nerr++; $display("FAIL shr got out=%h hi=%h fl=%b want C0 00 100100", ro, rh, rf);
    end
    drive(2, 'h80, 0, 0, 0, -1, ro, rh, rf, ed, bad);
    nvec++;
    if ({ro, rh, rf} !== {8'h00, 8'h00, 6'b101000}) begin
      nerr++; $display("FAIL shl got out=%h hi=%h fl=%b want 00 00 101000", ro, rh, rf);
    end
  endtask

  task automatic test_stall;
    logic [7:0] ro, rh; logic [5:0] rf; int ed, bad;
    drive(8, 'h12, 'h34, 0, 0, 2, ro, rh, rf, ed, bad);
    nvec++;
    if ({ro, rh, rf} !== {8'hA8, 8'h03, 6'b100100} || ed != 11) begin
      nerr++;
      $display("FAIL mul_stall got out=%h hi=%h fl=%b lat=%0d want A8 03 100100 11", ro, rh, rf, ed);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    op = 4'd9; a = 8'd200; b = 8'd7; ci = 1'b0; bcd = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({busy, out_valid, out, hi, z} !== {2'b00, 16'h0, 1'b1}) begin
      nerr++;
      $display("FAIL reset_mid got busy=%b ov=%b out=%h hi=%h z=%b want 0 0 00 00 1",
               busy, out_valid, out, hi, z);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL reset_mid_ready got %b want 1", in_ready);
    end
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    nvec++;
    if (seen != 0) begin
      nerr++; $display("FAIL reset_mid_abort got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_random;
    logic [7:0] ro, rh; logic [5:0] rf; logic [21:0] e;
    int ed, bad, o, x, y, c, d, want;
    for (int i = 0; i < 120; i++) begin
      o = $urandom_range(0, 15);
      x = $urandom_range(0, 255);
      y = (o == 9 && $urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
      c = $urandom_range(0, 1);
      d = $urandom_range(0, 1);
      e = model(o, x, y, c, d);
      want = (o == 8 || (o == 9 && y != 0)) ? 8 : 0;
      drive(o, x, y, c, d, -1, ro, rh, rf, ed, bad);
      nvec++;
      if ({ro, rh, rf} !== e || ed != want || bad != 0) begin
        nerr++;
        $display("FAIL rand op=%0d a=%h b=%h ci=%0d bcd=%0d got %h/%h/%b lat=%0d bad=%0d want %h/%h/%b lat=%0d",
                 o, x, y, c, d, ro, rh, rf, ed, bad, e[21:14], e[13:6], e[5:0], want);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [21:0] e;
    int o, x, y, c, d;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      o = $urandom_range(0, 7);
      x = $urandom_range(0, 255);
      y = $urandom_range(0, 255);
      c = $urandom_range(0, 1);
      d = $urandom_range(0, 1);
      op = 4'(o); a = 8'(x); b = 8'(y); ci = 1'(c); bcd = 1'(d);
      in_valid = 1'b1;
      e = model(o, x, y, c, d);
      @(posedge clk); #1;
      nvec++;
      if ({out_valid, out, hi, co, v, z, n, hc, dz} !== {1'b1, e}) begin
        nerr++;
        $display("FAIL b2b op=%0d a=%h b=%h got ov=%b %h/%h want 1 %h/%h", o, x, y,
                 out_valid, out, hi, e[21:14], e[13:6]);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    e = {out, hi, co, v, z, n, hc, dz};
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (out_valid !== 1'b1) begin
      nerr++; $display("FAIL stall_hold_valid got %b want 1", out_valid);
    end
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1;
    nvec++;
    if ({out_valid, out, hi, co, v, z, n, hc, dz} !== {1'b0, e}) begin
      nerr++;
      $display("FAIL valid_clear got ov=%b out=%h want 0 %h", out_valid, out, e[21:14]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_bcd();
    test_mul();
    test_div();
    test_shift();
    test_stall();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU, the next generation of the CPU datapath ALU. It adds a configurable data width and full decimal correction on add and subtract across every nibble. It also adds iterative unsigned multiply and divide behind a valid/ready handshake. All results and flags are registered and qualified by a global `en` stall.

## Interface
Parameters:
- `WIDTH`, 8, operand and result width in bits; a multiple of 4, minimum 4.
- `BCD_EN`, 1, when 0 the `bcd` input is ignored and the decimal logic is removed.

Ports:
- `clk`, in, 1, the single clock. All state changes on its rising edge.
- `rst_n`, in, 1, asynchronous active-low reset.
- `en`, in, 1, global stall; when 0, all state, counters and outputs hold.
- `in_valid`, in, 1, an operation is presented.
- `in_ready`, out, 1, equals `!busy & en`.
- `op`, in, 4, opcode (see Operation).
- `a`, in, WIDTH, operand A.
- `b`, in, WIDTH, operand B.
- `ci`, in, 1, carry in.
- `bcd`, in, 1, decimal mode for ADD and SUB.
- `out`, out, WIDTH, result: low half for MUL, quotient for DIV.
- `hi`, out, WIDTH, MUL high half or DIV remainder; 0 for all other ops.
- `out_valid`, out, 1, a new result is present.
- `busy`, out, 1, a multi-cycle op is in progress.
- `co`, `v`, `z`, `n`, `hc`, `dz`, out, 1 each, registered flags.

## Operation
- The op is accepted on the edge where `in_valid & in_ready` holds. Operands are latched on that edge.
- Opcodes and their results:
  - 0 ADD: `a+b+ci`.
  - 1 SUB: `a+~b+ci`; `co`=1 means no borrow.
  - 2 SHL: `{a,ci}`; `co`=`a[W-1]`.
  - 3 SHR: `{ci,a[W-1:1]}`; `co`=`a[0]`.
  - 4 OR, 5 AND, 6 XOR: bitwise on `a` and `b`.
  - 7 PASS: `a`.
  - 8 MUL: unsigned.
  - 9 DIV: unsigned, restoring.
  - 10–15: reserved, executed as PASS.
- Flag rules:
  - `n`=`out[W-1]`.
  - `z`=(`out`==0), except MUL, where `z`=(full 2W product ==0).
  - `v` (ADD/SUB only) = signed overflow of the binary sum before decimal correction; 0 otherwise.
  - `hc` = carry out of nibble 0 after correction, ADD/SUB only.
  - `dz` = 1 only for DIV with `b`==0.
  - Logic ops and PASS: `co`=0.
- Decimal mode (`bcd & BCD_EN`, ADD/SUB only), per nibble from LSB upward:
  - ADD: if the nibble sum >9, add 6 and carry 1 into the next nibble.
  - SUB: if the nibble produced no carry, subtract 6.
  - `co` = carry of the top nibble.
- MUL:
  - `{hi,out}` = `a*b`.
  - `co` = `|hi`; `v`=0; `hc`=0.
- DIV:
  - `out` = `a/b`; `hi` = `a%b`; `co`=0.
  - Divide by zero: `out`=all ones, `hi`=`a`, `dz`=1; completes as a single-cycle op.
- States: IDLE and RUN.
  - IDLE→RUN on accepting MUL, or DIV with `b`!=0.
  - RUN iterates WIDTH steps with a `$clog2(WIDTH+1)`-bit counter, then returns to IDLE.
- Reset values:
  - `out`, `hi`, `out_valid`, `busy`: 0.
  - `co`, `v`, `n`, `hc`, `dz`: 0.
  - `z`: 1, consistent with `out`=0.
  - State IDLE; counter 0.

## Timing
- Single-cycle ops: when accepted at edge t, result, flags and `out_valid`=1 are registered at edge t. Latency is 1.
- Multi-cycle ops accepted at edge t:
  - `busy`=1 from edge t.
  - Iterations run at edges t+1 through t+W−1.
  - Result, flags and `out_valid` are registered at edge t+W, where `busy` falls.
  - Latency is W enabled cycles.
- `out_valid` is high for exactly one enabled cycle. It stays high while `en`=0, and otherwise clears on the next edge unless a new result lands.
- `out`, `hi` and the flags hold their last value until the next completion.
- `in_valid` while `busy` is ignored, with no side effects.
- Accepting a new op in the cycle `out_valid` is high is legal.
- With `en`=0, nothing is accepted and no state advances. Each stalled cycle extends latency by one.
- Async reset mid-RUN aborts the op immediately and restores all reset values. The first accept is possible on the first enabled edge after `rst_n` rises.

## Structure
- `alu_mc_pkg` holds:
  - opcode localparams (`OP_ADD` … `OP_DIV`);
  - the state enum (`ST_IDLE`, `ST_RUN`);
  - the flag struct typedef.
- Sub-module `alu_mc_muldiv` contains the shift-add multiplier, the restoring divider, the counter and the FSM. Its interface is `start`, `is_div`, `a`, `b`, `en`, `done`, `lo`, `hi`.
- The top level holds:
  - the single-cycle datapath;
  - the per-nibble decimal correction, as a generate loop over WIDTH/4;
  - the output and flag registers;
  - the handshake.

## Test plan
All scenarios use WIDTH=8.
1. ADD `a`=0x7F, `b`=0x01, `ci`=0 → `out`=0x80, `v`=1, `n`=1, `co`=0, `z`=0; `out_valid` one cycle after accept.
2. BCD ADD 0x45+0x38, `ci`=0 → 0x83, `hc`=1, `co`=0. BCD SUB 0x42−0x15, `ci`=1 → 0x27, `co`=1. BCD ADD 0x99+0x01 → 0x00, `co`=1, `z`=1.
3. MUL 0xFF×0xFF → `out`=0x01, `hi`=0xFE, `co`=1. `out_valid` arrives 8 cycles after accept. `in_ready`=0 throughout, and an `in_valid` pulse mid-run is dropped.
4. DIV 200/7 → `out`=0x1C, `hi`=0x04, `dz`=0 after 8 cycles. DIV 200/0 → `out`=0xFF, `hi`=0xC8, `dz`=1 after 1 cycle.
5. SHR `a`=0x81, `ci`=1 → `out`=0xC0, `co`=1. SHL `a`=0x80, `ci`=0 → `out`=0x00, `co`=1, `z`=1.
6. MUL with `en`=0 for 3 cycles mid-run → latency 11. A separate DIV with `rst_n` pulsed low at iteration 4 → `busy`=0, `out_valid`=0, `out`=0, `z`=1, and `in_ready`=1 on the next enabled cycle.
